// File: rtl/m_seq_pkg.sv
// ============================================================================
// Module : m_seq_pkg
// Brief  : Shared constants and FSM state type for the DSSS chip encoder.
//          Optional feature macro: M_ENC_PREAMBLE_EN (adds PREAMBLE state).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package m_seq_pkg;

  localparam int SYM_LEN = 31;
  localparam int IDX_W   = 5;

  localparam logic [SYM_LEN-1:0] C_DEFAULT_TEMPLATE = 31'b1010000110010011111011100010101;

  localparam logic [IDX_W-1:0] C_IDX_TOP = IDX_W'(SYM_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
`ifdef M_ENC_PREAMBLE_EN
    ST_PREAMBLE = 2'd1,
`endif
    ST_SEND     = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/m_seq_enc.sv
// ============================================================================
// Module : m_seq_enc
// Brief  : Spreads each accepted data bit into a 31-chip sequence (TEMPLATE
//          or its complement), MSB first. Macro M_ENC_PREAMBLE_EN inserts a
//          TEMPLATE preamble ahead of a symbol that starts from idle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module m_seq_enc
  import m_seq_pkg::*;
#(
  parameter logic [SYM_LEN-1:0] TEMPLATE = C_DEFAULT_TEMPLATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic signal,
  output logic chip_valid,
  output logic symbol_start
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_d;
  logic             w_d_nxt;
  logic             w_accept;
  logic             w_sig_nxt;
  logic             w_valid_nxt;
  logic             w_start_nxt;

  // Gated by rst_n so the port reads 0 for the whole reset pulse.
  assign data_ready = rst_n & ((r_state == ST_IDLE) |
                               ((r_state == ST_SEND) & (r_idx == '0)));
  assign w_accept   = data_valid & data_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_d_nxt     = r_d;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_d_nxt   = data_in;
          w_idx_nxt = C_IDX_TOP;
`ifdef M_ENC_PREAMBLE_EN
          w_state_nxt = ST_PREAMBLE;
`else
          w_state_nxt = ST_SEND;
`endif
        end
      end
`ifdef M_ENC_PREAMBLE_EN
      ST_PREAMBLE: begin
        if (r_idx != '0) begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end else begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = C_IDX_TOP;
        end
      end
`endif
      ST_SEND: begin
        if (r_idx != '0) begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end else if (w_accept) begin
          // Back-to-back symbol: reload without a gap chip.
          w_d_nxt   = data_in;
          w_idx_nxt = C_IDX_TOP;
        end else begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = C_IDX_TOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = C_IDX_TOP;
      end
    endcase

    // Outputs are computed from the next state so they register in step with it.
    w_sig_nxt = 1'b0;
    case (w_state_nxt)
      ST_SEND:     w_sig_nxt = TEMPLATE[w_idx_nxt] ~^ w_d_nxt;
`ifdef M_ENC_PREAMBLE_EN
      ST_PREAMBLE: w_sig_nxt = TEMPLATE[w_idx_nxt];
`endif
      default:     w_sig_nxt = 1'b0;
    endcase
    w_valid_nxt = (w_state_nxt != ST_IDLE);
    w_start_nxt = w_valid_nxt & (w_idx_nxt == C_IDX_TOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= C_IDX_TOP;
      r_d          <= 1'b0;
      signal       <= 1'b0;
      chip_valid   <= 1'b0;
      symbol_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_d          <= w_d_nxt;
      signal       <= w_sig_nxt;
      chip_valid   <= w_valid_nxt;
      symbol_start <= w_start_nxt;
    end
  end

endmodule

`default_nettype wire
